reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file with a read-address pipeline stage, write-to-read bypass, a per-register busy scoreboard and a registered sideband payload stage. Sits between decode and execute. Captures source addresses and decode sideband on each accepted cycle. Presents operand data, a hazard flag and the payload to the ALU stage one cycle later. Writeback ports update the bank and clear busy bits.

## Interface
- XLEN, 32, data width of each register
- REG_NUM, 32, number of registers (≥2); AW = $clog2(REG_NUM)
- NRD, 2, number of read ports
- NWR, 1, number of write ports (1..4)
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, is never busy
- BYPASS, 1, when 1 same-cycle writes forward to read data and hazard
- FUR_W, 48, sideband payload width

Ports:
- clk  in  1  clock; all state on rising edge
- arstn  in  1  asynchronous active-low reset
- stall_i  in  1  hold: read addresses held, bubble inserted
- flush_i  in  1  kill the instruction being captured this cycle
- in_valid_i  in  1  decode slot holds an instruction
- rd_addr_i  in  NRD*AW  source addresses, port k at [k*AW +: AW]
- rsv_valid_i  in  1  instruction writes a destination
- rsv_addr_i  in  AW  destination to mark busy
- fur_i  in  FUR_W  sideband payload
- rd_data_o  out  NRD*XLEN  operand data, port k at [k*XLEN +: XLEN]
- hazard_o  out  1  some registered source is busy
- valid_o  out  1  registered instruction valid
- fur_o  out  FUR_W  registered payload
- wr_valid_i  in  NWR  write enables
- wr_addr_i  in  NWR*AW  write addresses
- wr_data_i  in  NWR*XLEN  write data

## Operation
- accept = in_valid_i & ~stall_i & ~flush_i.
- Address regs: when ~stall_i, addr_q[k] <= rd_addr_i[k]; else hold.
- Payload: when ~stall_i, fur_q <= fur_i; else hold.
- valid_q <= accept. A stall or a flush yields a bubble next cycle.
- Bank write: for each port j with wr_valid_i[j], bank[wr_addr_i[j]] <= wr_data_i[j]. If several ports write the same address, the highest j wins. Writes to reg 0 are dropped when ZERO_REG=1.
- Read: rd_data_o[k] = bank[addr_q[k]].
  - If BYPASS=1 and any port j has wr_valid_i[j] & wr_addr_i[j]==addr_q[k], the highest such j's wr_data_i is output.
  - Reg 0 reads 0 when ZERO_REG=1, overriding bypass.
- Scoreboard busy[REG_NUM]:
  - A write on any port clears busy[wr_addr].
  - accept & rsv_valid_i sets busy[rsv_addr_i].
  - If set and clear hit the same register in one cycle, set wins.
  - busy[0] is forced 0 when ZERO_REG=1.
- hazard_o = valid_q & OR over k of busy[addr_q[k]].
  - With BYPASS=1, a register being cleared by a write this cycle does not count as busy.
- valid_o = valid_q; fur_o = fur_q. Writes are never blocked by stall_i or flush_i.

## Timing
- Reset (async, arstn low): bank all 0, busy all 0, addr_q 0, fur_q 0, valid_q 0.
  - Resulting outputs: rd_data_o 0, hazard_o 0, valid_o 0, fur_o 0.
- Address/payload/valid latency: 1 cycle from capture to outputs.
- Write to bank visible: next cycle without bypass; same cycle with BYPASS=1 (combinational path wr_* -> rd_data_o/hazard_o).
- Busy set visible the cycle after accept. Busy clear visible same cycle with BYPASS=1, else the next cycle.
- Stall held N cycles: valid_o 0 for N cycles after the first. Addresses stay fixed, so rd_data_o tracks writes to the held addresses.
- Reset asserted mid-stall or with pending busy bits clears everything immediately; no write in that cycle takes effect.

## Test plan
- Reset then write r5=0xDEADBEEF (port 0), next cycle capture rd_addr={5,0}. One cycle later: rd_data port0=0xDEADBEEF, port1=0, valid_o=1.
- Bypass: registered addr r7; in the same cycle write r7=0x12345678. rd_data_o shows 0x12345678 that cycle (BYPASS=1); with BYPASS=0 it shows the old value until the next cycle.
- Scoreboard: accept with rsv_addr=3, next instruction reads r3 -> hazard_o=1. Write r3 -> hazard_o drops the same cycle; busy[3]=0 afterwards.
- Set/clear collision: accept rsv_addr=9 while port 0 writes r9 -> busy[9]=1 next cycle.
- Zero reg: write r0=0xFFFFFFFF and rsv_addr=0 -> reads of r0 return 0, hazard_o=0.
- Stall/flush: stall 3 cycles -> valid_o=0 for 3 cycles, addr_q unchanged. Flush with rsv_valid_i=1 -> valid_o=0 next cycle, busy bit not set.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file between decode and execute.
// Source addresses and decode sideband are captured on each cycle and
// presented one cycle later as operand data, a hazard flag and the payload.
// Writeback ports update the bank and retire busy bits in the scoreboard.
module reg_file_mp #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned REG_NUM  = 32,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 1,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned FUR_W    = 48,
   localparam int unsigned AW      = $clog2(REG_NUM)
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   input  logic [NRD*AW-1:0]     rd_addr_i,
   input  logic                  rsv_valid_i,
   input  logic [AW-1:0]         rsv_addr_i,
   input  logic [FUR_W-1:0]      fur_i,
   output logic [NRD*XLEN-1:0]   rd_data_o,
   output logic                  hazard_o,
   output logic                  valid_o,
   output logic [FUR_W-1:0]      fur_o,
   input  logic [NWR-1:0]        wr_valid_i,
   input  logic [NWR*AW-1:0]     wr_addr_i,
   input  logic [NWR*XLEN-1:0]   wr_data_i
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [XLEN-1:0]    bank_q [REG_NUM];
   logic [XLEN-1:0]    bank_d [REG_NUM];
   logic [REG_NUM-1:0] busy_q;
   logic [REG_NUM-1:0] busy_d;
   logic [AW-1:0]      addr_q [NRD];
   logic [AW-1:0]      addr_d [NRD];
   logic [FUR_W-1:0]   fur_q;
   logic [FUR_W-1:0]   fur_d;
   logic               valid_q;
   logic               valid_d;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic               accept_c;
   logic [REG_NUM-1:0] wr_clr_c;
   logic [XLEN-1:0]    rd_word_c [NRD];
   logic [NRD-1:0]     rd_busy_c;

   // True when the address names the hard-wired zero register.
   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // An instruction enters the pipeline only when it is real and not held or killed.
   assign accept_c = in_valid_i & ~stall_i & ~flush_i;

   // One-hot set of registers retired by a write this cycle (reg 0 excluded when hard-wired).
   always_comb begin
      wr_clr_c = '0;
      for (int unsigned j = 0; j < NWR; j++) begin
         if (wr_valid_i[j]) begin
            wr_clr_c[wr_addr_i[j*AW +: AW]] = 1'b1;
         end
      end
      if (ZERO_REG != 0) begin
         wr_clr_c[0] = 1'b0;
      end
   end

   // Bank update; later ports overwrite earlier ones so the highest port wins.
   always_comb begin
      bank_d = bank_q;
      for (int unsigned j = 0; j < NWR; j++) begin
         if (wr_valid_i[j] && !is_zero_reg(wr_addr_i[j*AW +: AW])) begin
            bank_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
         end
      end
   end

   // Scoreboard update; a reservation in the same cycle as a retire keeps the bit set.
   always_comb begin
      busy_d = busy_q & ~wr_clr_c;
      if (accept_c && rsv_valid_i) begin
         busy_d[rsv_addr_i] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // Capture stage: addresses and payload hold under stall, valid becomes a bubble.
   always_comb begin
      valid_d = accept_c;
      fur_d   = stall_i ? fur_q : fur_i;
      for (int unsigned k = 0; k < NRD; k++) begin
         addr_d[k] = stall_i ? addr_q[k] : rd_addr_i[k*AW +: AW];
      end
   end

   // Per-port operand lookup with optional write forwarding; the zero register overrides all.
   always_comb begin
      for (int unsigned k = 0; k < NRD; k++) begin
         rd_word_c[k] = bank_q[addr_q[k]];
         rd_busy_c[k] = busy_q[addr_q[k]];
         if (BYPASS != 0) begin
            for (int unsigned j = 0; j < NWR; j++) begin
               if (wr_valid_i[j] && (wr_addr_i[j*AW +: AW] == addr_q[k])) begin
                  rd_word_c[k] = wr_data_i[j*XLEN +: XLEN];
               end
            end
            if (wr_clr_c[addr_q[k]]) begin
               rd_busy_c[k] = 1'b0;
            end
         end
         if (is_zero_reg(addr_q[k])) begin
            rd_word_c[k] = '0;
            rd_busy_c[k] = 1'b0;
         end
      end
   end

   // Pack operand words onto the flat output bus.
   always_comb begin
      rd_data_o = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         rd_data_o[k*XLEN +: XLEN] = rd_word_c[k];
      end
   end

   // Hazard only matters for a live instruction.
   assign hazard_o = valid_q & (|rd_busy_c);
   assign valid_o  = valid_q;
   assign fur_o    = fur_q;

   // State registers; reset wipes bank, scoreboard and pipeline immediately.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         bank_q  <= '{default: '0};
         busy_q  <= '0;
         addr_q  <= '{default: '0};
         fur_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         bank_q  <= bank_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         fur_q   <= fur_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: two instances (bypass on / off, two write ports) driven
// with directed and random stimulus, compared against an array-based model.
module tb_reg_file_mp;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RN   = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NRD  = 2;
   localparam int unsigned NWR  = 2;
   localparam int unsigned FW   = 48;

   logic                clk = 1'b0;
   logic                arstn;
   logic                stall, flush, in_valid, rsv_valid;
   logic [NRD*AW-1:0]   rd_addr;
   logic [AW-1:0]       rsv_addr;
   logic [FW-1:0]       fur;
   logic [NWR-1:0]      wv;
   logic [NWR*AW-1:0]   wa;
   logic [NWR*XLEN-1:0] wd;

   logic [NRD*XLEN-1:0] rdata_b, rdata_n;
   logic                haz_b, haz_n, val_b, val_n;
   logic [FW-1:0]       fur_b, fur_n;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [XLEN-1:0] m_bank [RN];
   logic [RN-1:0]   m_busy;
   logic [AW-1:0]   m_addr [NRD];
   logic [FW-1:0]   m_fur;
   logic            m_valid;

   always #5 clk = ~clk;

   reg_file_mp #(.NWR(NWR), .BYPASS(1)) u_byp (
      .clk(clk), .arstn(arstn), .stall_i(stall), .flush_i(flush),
      .in_valid_i(in_valid), .rd_addr_i(rd_addr), .rsv_valid_i(rsv_valid),
      .rsv_addr_i(rsv_addr), .fur_i(fur), .rd_data_o(rdata_b),
      .hazard_o(haz_b), .valid_o(val_b), .fur_o(fur_b),
      .wr_valid_i(wv), .wr_addr_i(wa), .wr_data_i(wd));

   reg_file_mp #(.NWR(NWR), .BYPASS(0)) u_nob (
      .clk(clk), .arstn(arstn), .stall_i(stall), .flush_i(flush),
      .in_valid_i(in_valid), .rd_addr_i(rd_addr), .rsv_valid_i(rsv_valid),
      .rsv_addr_i(rsv_addr), .fur_i(fur), .rd_data_o(rdata_n),
      .hazard_o(haz_n), .valid_o(val_n), .fur_o(fur_n),
      .wr_valid_i(wv), .wr_addr_i(wa), .wr_data_i(wd));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < RN; i++) m_bank[i] = '0;
      m_busy  = '0;
      for (int k = 0; k < NRD; k++) m_addr[k] = '0;
      m_fur   = '0;
      m_valid = 1'b0;
   endtask

   function automatic logic written_now(input logic [AW-1:0] a);
      for (int j = 0; j < NWR; j++)
         if (wv[j] && wa[j*AW +: AW] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [XLEN-1:0] exp_data(input int k, input bit byp);
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      a = m_addr[k];
      d = m_bank[a];
      if (byp)
         for (int j = 0; j < NWR; j++)
            if (wv[j] && wa[j*AW +: AW] == a) d = wd[j*XLEN +: XLEN];
      if (a == 0) d = '0;
      return d;
   endfunction

   function automatic logic exp_hazard(input bit byp);
      logic [AW-1:0] a;
      if (!m_valid) return 1'b0;
      for (int k = 0; k < NRD; k++) begin
         a = m_addr[k];
         if (a != 0 && m_busy[a] && !(byp && written_now(a))) return 1'b1;
      end
      return 1'b0;
   endfunction

   // model the clock edge using the inputs present at that edge
   task automatic model_update();
      logic acc;
      if (!arstn) begin
         m_reset();
         return;
      end
      acc = in_valid & ~stall & ~flush;
      for (int j = 0; j < NWR; j++) begin
         if (wv[j] && wa[j*AW +: AW] != 0) m_bank[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
         if (wv[j]) m_busy[wa[j*AW +: AW]] = 1'b0;
      end
      if (acc && rsv_valid) m_busy[rsv_addr] = 1'b1;
      m_busy[0] = 1'b0;
      if (!stall) begin
         for (int k = 0; k < NRD; k++) m_addr[k] = rd_addr[k*AW +: AW];
         m_fur = fur;
      end
      m_valid = acc;
   endtask

   // called just after a falling edge with inputs set; checks, then advances one cycle
   task automatic step();
      #2;
      for (int k = 0; k < NRD; k++) begin
         chk($sformatf("rd%0d_byp", k), 64'(rdata_b[k*XLEN +: XLEN]), 64'(exp_data(k, 1'b1)));
         chk($sformatf("rd%0d_nob", k), 64'(rdata_n[k*XLEN +: XLEN]), 64'(exp_data(k, 1'b0)));
      end
      chk("haz_byp", 64'(haz_b), 64'(exp_hazard(1'b1)));
      chk("haz_nob", 64'(haz_n), 64'(exp_hazard(1'b0)));
      chk("valid_byp", 64'(val_b), 64'(m_valid));
      chk("valid_nob", 64'(val_n), 64'(m_valid));
      chk("fur_byp", 64'(fur_b), 64'(m_fur));
      chk("fur_nob", 64'(fur_n), 64'(m_fur));
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      stall = 0; flush = 0; in_valid = 0; rsv_valid = 0;
      rd_addr = '0; rsv_addr = '0; fur = '0; wv = '0; wa = '0; wd = '0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wv[j] = 1'b1;
      wa[j*AW +: AW] = a;
      wd[j*XLEN +: XLEN] = d;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, RN-1));
      return AW'($urandom_range(0, 7));
   endfunction

   task automatic randomize_inputs();
      stall     = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 10);
      in_valid  = ($urandom_range(0, 99) < 75);
      rsv_valid = ($urandom_range(0, 99) < 50);
      rsv_addr  = rnd_addr();
      set_rd(rnd_addr(), rnd_addr());
      fur = {16'($urandom), 32'($urandom)};
      wv = '0; wa = '0; wd = '0;
      for (int j = 0; j < NWR; j++)
         if ($urandom_range(0, 99) < 40) wr(j, rnd_addr(), 32'($urandom));
   endtask

   initial begin
      arstn = 1'b0;
      idle();
      m_reset();
      repeat (2) @(negedge clk);
      step();
      arstn = 1'b1;

      // basic write then read
      idle(); wr(0, 5, 32'hDEADBEEF); step();
      idle(); in_valid = 1; set_rd(5, 0); step();
      idle(); set_rd(5, 0); #1;
      chk("tp1_p0", 64'(rdata_b[31:0]), 64'h0000_0000_DEAD_BEEF);
      chk("tp1_p1", 64'(rdata_b[63:32]), 64'h0);
      chk("tp1_valid", 64'(val_b), 64'h1);
      step();

      // same-cycle write forwarding
      idle(); in_valid = 1; set_rd(7, 7); step();
      idle(); set_rd(7, 7); wr(0, 7, 32'h12345678); #1;
      chk("byp_same", 64'(rdata_b[31:0]), 64'h1234_5678);
      chk("nobyp_old", 64'(rdata_n[31:0]), 64'h0);
      step();
      idle(); set_rd(7, 7); #1;
      chk("nobyp_next", 64'(rdata_n[31:0]), 64'h1234_5678);
      step();

      // scoreboard set and retire
      idle(); in_valid = 1; rsv_valid = 1; rsv_addr = 3; step();
      idle(); in_valid = 1; set_rd(3, 1); step();
      idle(); in_valid = 1; set_rd(3, 1); #1;
      chk("haz_set_byp", 64'(haz_b), 64'h1);
      chk("haz_set_nob", 64'(haz_n), 64'h1);
      step();
      idle(); in_valid = 1; set_rd(3, 1); wr(0, 3, 32'hA5A5_0003); #1;
      chk("haz_clr_byp", 64'(haz_b), 64'h0);
      chk("haz_clr_nob", 64'(haz_n), 64'h1);
      step();
      idle(); in_valid = 1; set_rd(3, 1); #1;
      chk("haz_after_byp", 64'(haz_b), 64'h0);
      chk("haz_after_nob", 64'(haz_n), 64'h0);
      step();

      // reservation and retire of the same register in one cycle
      idle(); in_valid = 1; rsv_valid = 1; rsv_addr = 9; wr(0, 9, 32'h99); step();
      idle(); in_valid = 1; set_rd(1, 9); step();
      idle(); #1;
      chk("collide_byp", 64'(haz_b), 64'h1);
      chk("collide_nob", 64'(haz_n), 64'h1);
      step();

      // zero register
      idle(); in_valid = 1; rsv_valid = 1; rsv_addr = 0; wr(0, 0, 32'hFFFFFFFF); step();
      idle(); in_valid = 1; set_rd(0, 0); step();
      idle(); wr(1, 0, 32'hFFFFFFFF); #1;
      chk("zero_p0", 64'(rdata_b[31:0]), 64'h0);
      chk("zero_p1", 64'(rdata_b[63:32]), 64'h0);
      chk("zero_haz", 64'(haz_b), 64'h0);
      step();

      // stall for three cycles with addresses held
      idle(); in_valid = 1; set_rd(5, 7); step();
      for (int i = 0; i < 3; i++) begin
         idle(); stall = 1; in_valid = 1; set_rd(rnd_addr(), rnd_addr());
         if (i == 1) wr(0, 5, 32'h00C0FFEE);
         #1;
         if (i > 0) chk("stall_valid", 64'(val_b), 64'h0);
         chk("stall_p1", 64'(rdata_b[63:32]), 64'h1234_5678);
         step();
      end
      idle(); set_rd(5, 7); #1;
      chk("stall_end_valid", 64'(val_b), 64'h0);
      chk("stall_track", 64'(rdata_n[31:0]), 64'h00C0_FFEE);
      step();

      // flush kills the instruction and its reservation
      idle(); in_valid = 1; flush = 1; rsv_valid = 1; rsv_addr = 11; set_rd(11, 11); step();
      idle(); in_valid = 1; set_rd(11, 11); #1;
      chk("flush_valid", 64'(val_b), 64'h0);
      step();
      idle(); #1;
      chk("flush_nobusy", 64'(haz_b), 64'h0);
      chk("flush_next_valid", 64'(val_b), 64'h1);
      step();

      // random traffic with a mid-run asynchronous reset
      for (int i = 0; i < 800; i++) begin
         randomize_inputs();
         if (i == 400) begin
            arstn = 1'b0;
            m_reset();
            step();
            arstn = 1'b1;
         end else begin
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
